// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Releases STAGES downstream reset domains one at a time, in index order.
//   Each release is preceded by DELAY settle cycles and followed by a wait
//   for that domain's acknowledge, bounded by ACK_TIMEOUT cycles. Loss of PLL
//   lock re-asserts every domain and restarts the sequence. An acknowledge
//   timeout parks the block in a sticky error state until rst_in.
//
// Ports
//   clk_in      system clock, rising edge
//   rst_in      asynchronous active-high reset
//   clk_locked  PLL lock; low re-asserts all domains and restarts
//   stage_ack   per-domain alive acknowledge (level, clk_in domain)
//   rst_out     per-domain reset, active-high, registered
//   n_rst_out   bitwise inverse of rst_out
//   seq_done    all domains released and acknowledged
//   seq_error   acknowledge timeout seen (sticky until rst_in)
module reset_sequencer #(
  parameter int STAGES      = 3,
  parameter int DELAY       = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              clk_locked,
  input  logic [STAGES-1:0] stage_ack,
  output logic [STAGES-1:0] rst_out,
  output logic [STAGES-1:0] n_rst_out,
  output logic              seq_done,
  output logic              seq_error
);

  localparam int IW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int CW = $clog2(DELAY + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(STAGES - 1);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    ACK,
    DONE,
    ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [STAGES-1:0] rst_q, rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Acknowledge of the current stage, and a mask that clears only its reset bit.
  logic              ack_sel;
  logic [STAGES-1:0] rel_mask;

  always_comb begin
    ack_sel  = 1'b0;
    rel_mask = '1;
    for (int i = 0; i < STAGES; i++) begin
      if (idx_q == IW'(i)) begin
        ack_sel     = stage_ack[i];
        rel_mask[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    rst_d   = rst_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (clk_locked) begin
          state_d = COUNT;
          cnt_d   = '0;
        end
      end
      COUNT: begin
        if (cnt_q == CNT_LAST) begin
          // AND with the mask keeps earlier releases intact (monotonic per bit).
          rst_d   = rst_q & rel_mask;
          tcnt_d  = '0;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACK: begin
        // Ack is checked before the timeout so a last-cycle ack still succeeds.
        if (ack_sel) begin
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            cnt_d   = '0;
            state_d = COUNT;
          end
        end else if (tcnt_q == TMO_LAST) begin
          state_d = ERROR;
          rst_d   = '1;
          err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      DONE: begin
      end
      ERROR: begin
        // Terminal until rst_in; lock is deliberately ignored here.
      end
      default: state_d = IDLE;
    endcase

    // Lock loss overrides whatever the active states decided above.
    if (!clk_locked && (state_q == COUNT || state_q == ACK || state_q == DONE)) begin
      state_d = IDLE;
      rst_d   = '1;
      done_d  = 1'b0;
      idx_d   = '0;
      cnt_d   = '0;
      tcnt_d  = '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rst_out   = rst_q;
  assign n_rst_out = ~rst_q;
  assign seq_done  = done_q;
  assign seq_error = err_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer. Two instances: a 3-stage one (DELAY 4, timeout 8)
// and a 1-stage one (DELAY 1, timeout 2). Expected outputs come from a schedule
// of release / acknowledge / timeout edge numbers computed arithmetically from
// the per-stage ack delays, with an optional lock-loss window that restarts it.
module tb_reset_sequencer;

  localparam int INF = 1 << 30;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lock0 = 1'b0;
  logic       lock1 = 1'b0;
  logic [2:0] ack0 = '0;
  logic [0:0] ack1 = '0;
  logic [2:0] r0, nr0;
  logic       d0, e0;
  logic [0:0] r1, nr1;
  logic       d1, e1;

  reset_sequencer #(.STAGES(3), .DELAY(4), .ACK_TIMEOUT(8)) u0 (
    .clk_in(clk), .rst_in(rst), .clk_locked(lock0), .stage_ack(ack0),
    .rst_out(r0), .n_rst_out(nr0), .seq_done(d0), .seq_error(e0));

  reset_sequencer #(.STAGES(1), .DELAY(1), .ACK_TIMEOUT(2)) u1 (
    .clk_in(clk), .rst_in(rst), .clk_locked(lock1), .stage_ack(ack1),
    .rst_out(r1), .n_rst_out(nr1), .seq_done(d1), .seq_error(e1));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sel = 0;
  int S = 3, D = 4, T = 8;
  int noise_ones = 0;

  // Schedules: phase 0 starts at edge 1, phase 1 at the relock edge.
  int dly[2][3];
  int r_s[2][3];
  int a_s[2][3];
  int terr[2];

  function automatic void build(int p, int o);
    int t;
    t = o + D;
    terr[p] = 0;
    for (int k = 0; k < 3; k++) begin
      r_s[p][k] = INF;
      a_s[p][k] = INF;
    end
    for (int k = 0; k < S; k++) begin
      r_s[p][k] = t;
      if (dly[p][k] > T) begin
        terr[p] = t + T;
        break;
      end
      a_s[p][k] = t + dly[p][k];
      t = a_s[p][k] + D;
    end
  endfunction

  function automatic logic [2:0] exp_rst(int p, int e);
    logic [2:0] v;
    v = '0;
    for (int k = 0; k < S; k++)
      v[k] = (e < r_s[p][k]) || (terr[p] != 0 && e >= terr[p]);
    return v;
  endfunction

  function automatic logic exp_done(int p, int e);
    return (terr[p] == 0) && (e >= a_s[p][S-1]);
  endfunction

  function automatic logic exp_err(int p, int e);
    return (terr[p] != 0) && (e >= terr[p]);
  endfunction

  function automatic logic noise();
    return (noise_ones != 0) ? 1'b1 : 1'($urandom_range(0, 1));
  endfunction

  function automatic int pick_dly();
    case ($urandom_range(0, 3))
      0:       return 1;
      1:       return T;
      2:       return T + 1;
      default: return int'($urandom_range(1, T));
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; lock0 = 1'b0; lock1 = 1'b0; ack0 = '0; ack1 = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Runs n edges from IDLE. L = lock-loss edge (0 = none), R = relock edge.
  task automatic run_scenario(input string name, input int L, input int R, input int n);
    int ph;
    logic lk;
    logic [2:0] av, er, mask, o_r, o_nr;
    logic ed, ee, o_d, o_e;
    bit hold;
    mask = 3'((1 << S) - 1);
    build(0, 1);
    if (L > 0) build(1, R);
    hold = (L == 0) || (terr[0] != 0 && terr[0] < L);
    for (int e = 1; e <= n; e++) begin
      if (hold || e < L) ph = 0;
      else if (e < R)    ph = -1;
      else               ph = 1;
      av = '0;
      if (ph < 0) begin
        lk = 1'b0;
        for (int k = 0; k < S; k++) av[k] = noise();
      end else begin
        lk = (terr[ph] != 0 && e > terr[ph]) ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int k = 0; k < S; k++) begin
          if (e <= r_s[ph][k] || (terr[ph] != 0 && e > terr[ph])) av[k] = noise();
          else av[k] = (e >= a_s[ph][k]);
        end
      end
      if (sel == 0) begin lock0 = lk; ack0 = av; end
      else begin lock1 = lk; ack1 = av[0]; end
      @(posedge clk);
      #1;
      if (ph < 0) begin er = mask; ed = 1'b0; ee = 1'b0; end
      else begin er = exp_rst(ph, e); ed = exp_done(ph, e); ee = exp_err(ph, e); end
      o_r  = (sel == 0) ? r0  : {2'b00, r1};
      o_nr = (sel == 0) ? nr0 : {2'b00, nr1};
      o_d  = (sel == 0) ? d0  : d1;
      o_e  = (sel == 0) ? e0  : e1;
      checks++;
      if (o_r !== er) begin
        errors++;
        $display("FAIL %s rst_out edge %0d: got %b want %b", name, e, o_r, er);
      end
      checks++;
      if (o_nr !== (~er & mask)) begin
        errors++;
        $display("FAIL %s n_rst_out edge %0d: got %b want %b", name, e, o_nr, ~er & mask);
      end
      checks++;
      if (o_d !== ed) begin
        errors++;
        $display("FAIL %s seq_done edge %0d: got %b want %b", name, e, o_d, ed);
      end
      checks++;
      if (o_e !== ee) begin
        errors++;
        $display("FAIL %s seq_error edge %0d: got %b want %b", name, e, o_e, ee);
      end
    end
  endtask

  task automatic set_dly(input int p, input int a, input int b, input int c);
    dly[p][0] = a; dly[p][1] = b; dly[p][2] = c;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (r0 !== 3'b111 || nr0 !== 3'b000 || d0 !== 1'b0 || e0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_u0: got rst=%b nrst=%b done=%b err=%b want 111 000 0 0", r0, nr0, d0, e0);
    end
    checks++;
    if (r1 !== 1'b1 || nr1 !== 1'b0 || d1 !== 1'b0 || e1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_u1: got rst=%b nrst=%b done=%b err=%b want 1 0 0 0", r1, nr1, d1, e1);
    end
    @(negedge clk);
    rst = 1'b0;
    // Unlocked: stays idle with everything held in reset.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (r0 !== 3'b111 || d0 !== 1'b0 || r1 !== 1'b1 || d1 !== 1'b0) begin
        errors++;
        $display("FAIL idle_unlocked: got r0=%b d0=%b r1=%b d1=%b want 111 0 1 0", r0, d0, r1, d1);
      end
    end
  endtask

  task automatic test_nominal();
    set_dly(0, 1, 1, 1);
    run_scenario("nominal", 0, 0, 22);
    do_reset();
    noise_ones = 1;
    set_dly(0, 2, 5, 3);
    run_scenario("nominal_noisy", 0, 0, 40);
    noise_ones = 0;
    do_reset();
  endtask

  task automatic test_timeout();
    set_dly(0, 1, 9, 1);
    run_scenario("timeout", 0, 0, 30);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (e0 !== 1'b0 || r0 !== 3'b111) begin
      errors++;
      $display("FAIL timeout_clear: got err=%b rst=%b want 0 111", e0, r0);
    end
    @(negedge clk);
    rst = 1'b0;
    do_reset();
  endtask

  task automatic test_lock_loss();
    set_dly(0, 1, 1, 1);
    set_dly(1, 1, 1, 1);
    run_scenario("lock_loss", 7, 9, 40);
    do_reset();
    // Lock drops on the very edge stage 1's ack is sampled.
    set_dly(0, 2, 3, 1);
    set_dly(1, 1, 2, 3);
    build(0, 1);
    run_scenario("lock_vs_ack", a_s[0][1], a_s[0][1] + 3, 60);
    do_reset();
    // Lock loss after completion.
    set_dly(0, 1, 1, 1);
    set_dly(1, 1, 1, 1);
    run_scenario("lock_after_done", 20, 22, 45);
    do_reset();
  endtask

  task automatic test_simultaneous();
    set_dly(0, T, T, T);
    run_scenario("ack_at_timeout", 0, 0, 50);
    do_reset();
  endtask

  task automatic test_wrong_stage();
    noise_ones = 1;
    set_dly(0, T + 1, 1, 1);
    run_scenario("wrong_stage_ack", 0, 0, 20);
    noise_ones = 0;
    do_reset();
  endtask

  task automatic test_async_reset();
    set_dly(0, 1, 2, 1);
    run_scenario("pre_async", 0, 0, 22);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (r0 !== 3'b111 || nr0 !== 3'b000 || d0 !== 1'b0 || e0 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got rst=%b nrst=%b done=%b err=%b want 111 000 0 0", r0, nr0, d0, e0);
    end
    @(negedge clk);
    rst = 1'b0;
    do_reset();
  endtask

  task automatic test_random();
    int L, R, lmax;
    lmax = (sel == 0) ? 40 : 10;
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < 3; k++) begin
        dly[0][k] = pick_dly();
        dly[1][k] = pick_dly();
      end
      if ($urandom_range(0, 1) == 0) begin L = 0; R = 0; end
      else begin
        L = int'($urandom_range(2, lmax));
        R = L + int'($urandom_range(1, 4));
      end
      noise_ones = int'($urandom_range(0, 1));
      run_scenario("random", L, R, (sel == 0) ? 100 : 30);
      noise_ones = 0;
      do_reset();
    end
  endtask

  task automatic test_corner();
    sel = 1; S = 1; D = 1; T = 2;
    set_dly(0, 1, 1, 1);
    run_scenario("c1_nominal", 0, 0, 8);
    do_reset();
    set_dly(0, 2, 1, 1);
    run_scenario("c1_ack_at_timeout", 0, 0, 8);
    do_reset();
    set_dly(0, 3, 1, 1);
    run_scenario("c1_timeout", 0, 0, 10);
    do_reset();
    set_dly(0, 1, 1, 1);
    set_dly(1, 2, 1, 1);
    run_scenario("c1_lock_loss", 3, 5, 12);
    do_reset();
    test_random();
    sel = 0; S = 3; D = 4; T = 8;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_lock_loss();
    test_simultaneous();
    test_wrong_stage();
    test_async_reset();
    test_random();
    test_corner();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
